// File: rtl/stepper_move_ctrl.sv
// stepper_move_ctrl: move controller feeding the one-hot stepper phase rotator.
// Accepts (steps, dir, period) commands and emits one step_pulse per step.
// The absolute position is tracked in two's complement.
// Optional linear accel/decel ramp is enabled by defining STEPPER_MOVE_RAMP_EN.
module stepper_move_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned PER_W        = 16,
  parameter int unsigned POS_W        = 16,
  parameter int unsigned START_PERIOD = 1000,
  parameter int unsigned RAMP_DEC     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

  state_t           r_state, w_state_nx;
  logic             r_live, r_zero, r_done, r_pulse, r_dir;
  logic [CNT_W-1:0] r_rem, w_rem_abort;
  logic [PER_W-1:0] r_tmr, r_pc, w_pc, w_p0_in, w_per_nx;
  logic [POS_W-1:0] r_pos;
  logic             w_accept, w_moving, w_tick, w_step, w_abort;

  assign w_pc     = (cmd_period < PER_W'(2)) ? PER_W'(2) : cmd_period;
  assign w_accept = cmd_valid & cmd_ready;
  assign w_moving = (r_state != S_IDLE);
  assign w_abort  = abort && ((r_state == S_ACCEL) || (r_state == S_CRUISE));
  assign w_tick   = w_moving && (r_tmr == PER_W'(1));
  // An abort cycle swallows a coincident timer expiry so the trimmed count is exact.
  assign w_step   = w_tick && (r_rem != '0) && !w_abort;

`ifdef STEPPER_MOVE_RAMP_EN
  localparam logic [PER_W-1:0] LP_START = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] LP_DEC   = PER_W'(RAMP_DEC);

  logic [PER_W-1:0] r_per, r_p0, w_per_acc, w_per_dcl;
  logic [CNT_W-1:0] r_ramp, w_rem_dec;
  logic             w_to_decel, w_acc_upd, w_dec_upd;

  assign w_p0_in   = (w_pc < LP_START) ? LP_START : w_pc;
  assign w_rem_dec = r_rem - CNT_W'(1);
  // The step that brings remaining down to the ramp count is already a decel step,
  // so the number of period increases mirrors the number of decreases.
  assign w_to_decel = w_step && ((r_state == S_ACCEL) || (r_state == S_CRUISE))
                      && (w_rem_dec <= r_ramp);
  assign w_dec_upd  = w_step && ((r_state == S_DECEL) || w_to_decel);
  assign w_acc_upd  = w_step && (r_state == S_ACCEL) && !w_to_decel;
  assign w_per_acc  = ((r_per - r_pc) <= LP_DEC) ? r_pc : (r_per - LP_DEC);
  assign w_per_dcl  = ((r_p0 - r_per) <= LP_DEC) ? r_p0 : (r_per + LP_DEC);
  assign w_per_nx   = w_dec_upd ? w_per_dcl : (w_acc_upd ? w_per_acc : r_per);
  assign w_rem_abort = (r_rem < r_ramp) ? r_rem : r_ramp;

  // Ramp state: current period, ramp start period and ramp step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per  <= '0;
      r_p0   <= '0;
      r_ramp <= '0;
    end else if (w_accept) begin
      r_per  <= w_p0_in;
      r_p0   <= w_p0_in;
      r_ramp <= '0;
    end else if (w_moving) begin
      r_per <= w_per_nx;
      if (w_acc_upd)
        r_ramp <= r_ramp + CNT_W'(1);
      else if (w_dec_upd && (r_ramp != '0))
        r_ramp <= r_ramp - CNT_W'(1);
    end
  end
`else
  assign w_p0_in     = w_pc;
  assign w_per_nx    = r_pc;
  assign w_rem_abort = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (cmd_steps != '0)) begin
`ifdef STEPPER_MOVE_RAMP_EN
          w_state_nx = (w_p0_in == w_pc) ? S_CRUISE : S_ACCEL;
`else
          w_state_nx = S_CRUISE;
`endif
        end
      end
      S_ACCEL, S_CRUISE: begin
        if (r_rem == '0)
          w_state_nx = S_IDLE;
`ifdef STEPPER_MOVE_RAMP_EN
        else if (w_abort || w_to_decel)
          w_state_nx = S_DECEL;
        else if (w_acc_upd && (w_per_acc == r_pc))
          w_state_nx = S_CRUISE;
`endif
      end
      S_DECEL: begin
        if (r_rem == '0) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    cmd_ready = r_live && (r_state == S_IDLE) && !r_zero;
    busy      = w_moving;
  end

  // Move datapath: step timer, remaining count, strobes and position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_pulse <= 1'b0;
      r_dir   <= 1'b0;
      r_rem   <= '0;
      r_tmr   <= '0;
      r_pc    <= '0;
      r_pos   <= '0;
    end else begin
      r_live  <= 1'b1;
      r_zero  <= w_accept && (cmd_steps == '0);
      r_done  <= r_zero || (w_moving && (w_state_nx == S_IDLE));
      r_pulse <= w_step;
      if (w_accept) begin
        r_dir <= cmd_dir;
        r_rem <= cmd_steps;
        r_pc  <= w_pc;
        r_tmr <= w_p0_in;
      end else if (w_moving) begin
        r_tmr <= (r_tmr == PER_W'(1)) ? w_per_nx : (r_tmr - PER_W'(1));
        if (w_abort)
          r_rem <= w_rem_abort;
        else if (w_step)
          r_rem <= r_rem - CNT_W'(1);
        if (w_step)
          r_pos <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
      end
    end
  end

  assign step_pulse = r_pulse;
  assign step_dir   = r_dir;
  assign done       = r_done;
  assign position   = r_pos;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed, table-driven bench for stepper_move_ctrl (both ramp builds).
`timescale 1ns/1ps
module tb_stepper_move_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        cmd_ready, step_pulse, step_dir, busy, done;
  logic [15:0] position;

  stepper_move_ctrl #(
    .CNT_W(16), .PER_W(16), .POS_W(16), .START_PERIOD(20), .RAMP_DEC(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .abort(abort), .step_pulse(step_pulse), .step_dir(step_dir),
    .busy(busy), .done(done), .position(position)
  );

  always #5 clk = ~clk;

`ifdef STEPPER_MOVE_RAMP_EN
  localparam int BP0 = 20;
`else
  localparam int BP0 = 2;
`endif

  typedef struct {
    int steps; int dir; int per;
    int ab;          // abort after this many pulses (-1: never)
    int np;          // expected pulse count
    int dn;          // expected done cycle relative to accept edge
    logic [5:0][15:0] ivl;  // expected pulse intervals
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cur_id = -1;
  logic [15:0] m_pos = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s [vec %0d] t=%0t: got %0d, want %0d", nm, cur_id, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input int st, input int d, input int p, input int ab,
                              input int np, input int dn, input int i0, input int i1,
                              input int i2, input int i3, input int i4, input int i5);
    vec_t v;
    v.steps = st; v.dir = d; v.per = p; v.ab = ab; v.np = np; v.dn = dn;
    v.ivl[0] = 16'(i0); v.ivl[1] = 16'(i1); v.ivl[2] = 16'(i2);
    v.ivl[3] = 16'(i3); v.ivl[4] = 16'(i4); v.ivl[5] = 16'(i5);
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int k, np, prev, dn;
    logic [15:0] pos_end;
    pos_end = (v.dir != 0) ? m_pos + 16'(v.np) : m_pos - 16'(v.np);
    k = 0;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_steps = 16'(v.steps); cmd_dir = v.dir[0]; cmd_period = 16'(v.per);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ready_low", cmd_ready, 0);
    chk("dir_latch", step_dir, v.dir);
    chk("busy_start", busy, (v.steps != 0) ? 1 : 0);
    np = 0; prev = 0; dn = -1; k = 0;
    if (v.ab == 0) abort = 1'b1;
    while (dn < 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
      abort = 1'b0;
      if (step_pulse) begin
        m_pos = (v.dir != 0) ? m_pos + 16'd1 : m_pos - 16'd1;
        chk("pos_step", position, m_pos);
        chk("dir_step", step_dir, v.dir);
        if (np < 6) chk("interval", k - prev, v.ivl[np]);
        np++;
        prev = k;
        if (np == v.ab) abort = 1'b1;
      end
      if (done) begin
        dn = k;
        chk("busy_end", busy, 0);
        chk("ready_end", cmd_ready, 1);
      end
    end
    chk("npulse", np, v.np);
    chk("done_at", dn, v.dn);
    chk("pos_final", position, pos_end);
    m_pos = pos_end;
    @(posedge clk); #1;
    chk("done_1cyc", done, 0);
  endtask

  initial begin : main
    int k;
    int p_t[$];
    int d_t[$];
    logic seen;

`ifdef STEPPER_MOVE_RAMP_EN
    tbl.push_back(mk(6, 1, 10, -1, 6, 91,  20, 15, 10, 10, 15, 20));
    tbl.push_back(mk(0, 1, 10, -1, 0, 1,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 30, -1, 5, 151, 30, 30, 30, 30, 30, 0));
    tbl.push_back(mk(3, 0, 20, -1, 3, 61,  20, 20, 20, 0, 0, 0));
    tbl.push_back(mk(10, 1, 10, 3, 5, 71,  20, 15, 10, 10, 15, 0));
    tbl.push_back(mk(4, 1, 10, -1, 4, 61,  20, 15, 10, 15, 0, 0));
    tbl.push_back(mk(1, 1, 10, -1, 1, 21,  20, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 1, 10, 0, 0, 2,    0, 0, 0, 0, 0, 0));
`else
    tbl.push_back(mk(5, 1, 4, -1, 5, 21,   4, 4, 4, 4, 4, 0));
    tbl.push_back(mk(0, 1, 4, -1, 0, 1,    0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 1, -1, 4, 9,    2, 2, 2, 2, 0, 0));
    tbl.push_back(mk(3, 0, 2, -1, 3, 7,    2, 2, 2, 0, 0, 0));
    tbl.push_back(mk(6, 1, 3, 2, 2, 8,     3, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, -1, 1, 3,    2, 0, 0, 0, 0, 0));
`endif

    // Reset with a command presented.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd4; cmd_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_dir", step_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", position, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", cmd_ready, 1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (step_pulse || busy) seen = 1'b1;
    end
    chk("rel_quiet", seen, 0);

    foreach (tbl[i]) begin
      cur_id = i;
      run_vec(tbl[i]);
    end

    // Back-to-back: a held command is accepted in the done cycle of the previous move.
    cur_id = 100;
    cmd_valid = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd2; cmd_dir = 1'b1;
    chk("b2b_ready", cmd_ready, 1);
    @(posedge clk); #1;
    for (k = 1; k <= 2 * BP0 + 6; k++) begin
      @(posedge clk); #1;
      if (k == BP0 + 2) cmd_valid = 1'b0;
      if (step_pulse) p_t.push_back(k);
      if (done) d_t.push_back(k);
    end
    chk("b2b_npulse", p_t.size(), 2);
    chk("b2b_ndone", d_t.size(), 2);
    if (p_t.size() == 2) begin
      chk("b2b_p0", p_t[0], BP0);
      chk("b2b_p1", p_t[1], 2 * BP0 + 2);
    end
    if (d_t.size() == 2) begin
      chk("b2b_d0", d_t[0], BP0 + 1);
      chk("b2b_d1", d_t[1], 2 * BP0 + 3);
    end
    m_pos = m_pos + 16'd2;
    chk("b2b_pos", position, m_pos);

    // Reset in the middle of a move: immediate stop, no done.
    cur_id = 101;
    cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd30; cmd_dir = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (step_pulse) seen = 1'b1;
    end
    chk("mid_first_pulse", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_pos", position, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", cmd_ready, 0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || step_pulse || busy) seen = 1'b1;
    end
    chk("mid_no_activity", seen, 0);
    chk("mid_ready_after", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
